// File: rtl/debug_seg_mux.sv
// debug_seg_mux: channel-selectable debug value on a multiplexed 7-segment display.
// Picks one of CH 32-bit debug channels, either from a debounced step button or
// by timed auto-rotation. The chosen value is captured once per display frame,
// so a frame never mixes channels or half-updated values.
// Optional build macro: DEBUG_SEG_CHTAG_EN -- the top digit shows the channel
// index (dp lit) instead of a value nibble.
module debug_seg_mux #(
  parameter int CH         = 8,
  parameter int DIGITS     = 8,
  parameter int SCAN_DIV   = 100000,
  parameter int ROT_DIV    = 200000000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    step,
  input  logic                    auto_en,
  input  logic [CH*32-1:0]        ch_data,
  output logic [7:0]              o_seg,
  output logic [DIGITS-1:0]       o_sel,
  output logic [$clog2(CH)-1:0]   cur_ch
);

  localparam int CH_W   = $clog2(CH);
  localparam int DIG_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SCAN_W = $clog2(SCAN_DIV + 1);
  localparam int ROT_W  = $clog2(ROT_DIV + 1);
  localparam int DEB_W  = $clog2(DEB_CYCLES + 1);

  // Active-low hex font, dp off.
  function automatic logic [7:0] hex_seg(input logic [3:0] n);
    case (n)
      4'h0:    hex_seg = 8'hC0;
      4'h1:    hex_seg = 8'hF9;
      4'h2:    hex_seg = 8'hA4;
      4'h3:    hex_seg = 8'hB0;
      4'h4:    hex_seg = 8'h99;
      4'h5:    hex_seg = 8'h92;
      4'h6:    hex_seg = 8'h82;
      4'h7:    hex_seg = 8'hF8;
      4'h8:    hex_seg = 8'h80;
      4'h9:    hex_seg = 8'h90;
      4'hA:    hex_seg = 8'h88;
      4'hB:    hex_seg = 8'h83;
      4'hC:    hex_seg = 8'hC6;
      4'hD:    hex_seg = 8'hA1;
      4'hE:    hex_seg = 8'h86;
      default: hex_seg = 8'h8E;
    endcase
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchroniser and debounce
  // ---------------------------------------------------------------------------
  logic             sync1_q, sync2_q;
  logic             deb_level_q, deb_level_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;
  logic             step_pulse_q, step_pulse_d;

  // Two-flop synchroniser for the asynchronous push-button.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= step;
      sync2_q <= sync1_q;
    end
  end

  // Down-counter reloads on every sample that agrees with the debounced level;
  // reaching zero on a differing sample means DEB_CYCLES differing samples in a row.
  always_comb begin
    deb_level_d = deb_level_q;
    deb_cnt_d   = DEB_W'(DEB_CYCLES - 1);
    if (sync2_q != deb_level_q) begin
      if (deb_cnt_q == '0) begin
        deb_level_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q - 1'b1;
      end
    end
    step_pulse_d = deb_level_d & ~deb_level_q;
  end

  // Debounce state and the registered press pulse (release never pulses).
  always_ff @(posedge clk) begin
    if (!reset) begin
      deb_level_q  <= 1'b0;
      deb_cnt_q    <= DEB_W'(DEB_CYCLES - 1);
      step_pulse_q <= 1'b0;
    end else begin
      deb_level_q  <= deb_level_d;
      deb_cnt_q    <= deb_cnt_d;
      step_pulse_q <= step_pulse_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Auto-rotation and channel selection
  // ---------------------------------------------------------------------------
  logic             rot_tick;
  logic [ROT_W-1:0] rot_q, rot_d;
  logic [CH_W-1:0]  cur_ch_q, cur_ch_d;

  // A manual step restarts the rotation period so the new channel gets a full slot.
  always_comb begin
    rot_tick = auto_en && (rot_q == ROT_W'(ROT_DIV - 1));
    if (!auto_en || step_pulse_q || rot_tick) begin
      rot_d = '0;
    end else begin
      rot_d = rot_q + 1'b1;
    end
    cur_ch_d = cur_ch_q;
    if (step_pulse_q || rot_tick) begin
      cur_ch_d = (cur_ch_q == CH_W'(CH - 1)) ? '0 : cur_ch_q + 1'b1;
    end
  end

  // Rotation counter and selected channel.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rot_q    <= '0;
      cur_ch_q <= '0;
    end else begin
      rot_q    <= rot_d;
      cur_ch_q <= cur_ch_d;
    end
  end

  assign cur_ch = cur_ch_q;

  // ---------------------------------------------------------------------------
  // Digit scan and per-frame snapshot
  // ---------------------------------------------------------------------------
  logic              scan_wrap;
  logic              frame_bnd;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic [DIG_W-1:0]  digit_q, digit_d;
  logic [31:0]       snap_q, snap_d;

  // Frame boundary is the cycle the digit index wraps back to 0; the snapshot
  // loads there using cur_ch as it stood before this edge.
  always_comb begin
    scan_wrap = (scan_q == SCAN_W'(SCAN_DIV - 1));
    frame_bnd = scan_wrap && (digit_q == DIG_W'(DIGITS - 1));
    scan_d    = scan_wrap ? '0 : scan_q + 1'b1;
    digit_d   = digit_q;
    if (scan_wrap) begin
      digit_d = (digit_q == DIG_W'(DIGITS - 1)) ? '0 : digit_q + 1'b1;
    end
    snap_d = frame_bnd ? ch_data[32*cur_ch_q +: 32] : snap_q;
  end

  // Prescaler, digit index and snapshot value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      scan_q  <= '0;
      digit_q <= '0;
      snap_q  <= '0;
    end else begin
      scan_q  <= scan_d;
      digit_q <= digit_d;
      snap_q  <= snap_d;
    end
  end

`ifdef DEBUG_SEG_CHTAG_EN
  logic [CH_W-1:0] tag_q;

  // Channel index captured alongside the snapshot so the tag matches the value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tag_q <= '0;
    end else if (frame_bnd) begin
      tag_q <= cur_ch_q;
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Segment decode and output registers
  // ---------------------------------------------------------------------------
  logic [3:0]        nib;
  logic [7:0]        seg_d, o_seg_q;
  logic [DIGITS-1:0] sel_d, o_sel_q;

  // Decode the nibble for the current digit; outputs lag the index by one cycle.
  always_comb begin
    nib   = snap_q[4*digit_q +: 4];
    seg_d = hex_seg(nib);
`ifdef DEBUG_SEG_CHTAG_EN
    if (digit_q == DIG_W'(DIGITS - 1)) begin
      seg_d = hex_seg(4'(tag_q)) & 8'h7F;
    end
`endif
    sel_d = ~(DIGITS'(1) << digit_q);
  end

  // Registered display drive; blank with all digits off in reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      o_seg_q <= 8'hFF;
      o_sel_q <= '1;
    end else begin
      o_seg_q <= seg_d;
      o_sel_q <= sel_d;
    end
  end

  assign o_seg = o_seg_q;
  assign o_sel = o_sel_q;

endmodule

// File: tb/tb_debug_seg_mux.sv
// Directed bench for debug_seg_mux with CH=3, DIGITS=4, SCAN_DIV=4, ROT_DIV=50,
// DEB_CYCLES=3. Expected values are hand-derived from the cycle timing.
module tb_debug_seg_mux;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        step = 1'b0;
  logic        auto_en = 1'b0;
  logic [31:0] ch0 = 32'h0;
  logic [31:0] ch1 = 32'h89AB_CDEF;
  logic [31:0] ch2 = 32'h0000_7654;
  logic [95:0] ch_data;
  logic [7:0]  o_seg;
  logic [3:0]  o_sel;
  logic [1:0]  cur_ch;

  int total = 0;
  int bad   = 0;

  assign ch_data = {ch2, ch1, ch0};

  debug_seg_mux #(
    .CH(3), .DIGITS(4), .SCAN_DIV(4), .ROT_DIV(50), .DEB_CYCLES(3)
  ) dut (
    .clk(clk), .reset(reset), .step(step), .auto_en(auto_en),
    .ch_data(ch_data), .o_seg(o_seg), .o_sel(o_sel), .cur_ch(cur_ch)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if (o_seg !== 8'hFF || o_sel !== 4'b1111 || cur_ch !== 2'd0) begin
        bad++;
        $display("FAIL reset_hold: seg=%h sel=%b ch=%0d want seg=ff sel=1111 ch=0",
                 o_seg, o_sel, cur_ch);
      end
    end
  endtask

  // Frame 0 shows the reset snapshot (0), frame 1 captures 1A2F, ch0 changes
  // mid-frame 1 without disturbing it, frame 2 shows FFFF.
  task automatic test_frame_snapshot();
    logic [7:0] exp_tab [3][4];
    logic [3:0] exp_sel;
    int f, d;
    exp_tab[0] = '{8'hC0, 8'hC0, 8'hC0, 8'hC0};
    exp_tab[1] = '{8'h8E, 8'hA4, 8'h88, 8'hF9};
    exp_tab[2] = '{8'h8E, 8'h8E, 8'h8E, 8'h8E};
`ifdef DEBUG_SEG_CHTAG_EN
    exp_tab[0][3] = 8'h40;
    exp_tab[1][3] = 8'h40;
    exp_tab[2][3] = 8'h40;
`endif
    reset = 1'b1;
    ch0   = 32'h0000_1A2F;
    for (int e = 1; e <= 48; e++) begin
      tick();
      f = (e - 1) / 16;
      d = ((e - 1) % 16) / 4;
      exp_sel = 4'b1111;
      exp_sel[d] = 1'b0;
      total++;
      if (o_seg !== exp_tab[f][d] || o_sel !== exp_sel) begin
        bad++;
        $display("FAIL frame_snapshot e=%0d: seg=%h sel=%b want seg=%h sel=%b",
                 e, o_seg, o_sel, exp_tab[f][d], exp_sel);
      end
      if (e == 24) ch0 = 32'h0000_FFFF;
    end
  endtask

  task automatic test_debounce();
    for (int i = 0; i < 20; i++) begin
      step = (i % 4) < 2;
      tick();
    end
    total++;
    if (cur_ch !== 2'd0) begin
      bad++;
      $display("FAIL debounce_bounce: ch=%0d want 0", cur_ch);
    end
    step = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (i == 5) begin
        total++;
        if (cur_ch !== 2'd0) begin
          bad++;
          $display("FAIL debounce_early: ch=%0d want 0", cur_ch);
        end
      end
      if (i == 6) begin
        total++;
        if (cur_ch !== 2'd1) begin
          bad++;
          $display("FAIL debounce_edge: ch=%0d want 1", cur_ch);
        end
      end
    end
    step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (cur_ch !== 2'd1) begin
      bad++;
      $display("FAIL debounce_release: ch=%0d want 1", cur_ch);
    end
  endtask

  task automatic test_wrap_auto();
    int chk_e [6] = '{49, 50, 69, 70, 119, 120};
    logic [1:0] chk_v [6] = '{2'd2, 2'd0, 2'd0, 2'd1, 2'd1, 2'd2};
    step = 1'b1;
    for (int i = 0; i < 8; i++) tick();
    step = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    total++;
    if (cur_ch !== 2'd2) begin
      bad++;
      $display("FAIL wrap_setup: ch=%0d want 2", cur_ch);
    end
    auto_en = 1'b1;
    for (int e = 1; e <= 120; e++) begin
      tick();
      for (int k = 0; k < 6; k++) begin
        if (chk_e[k] == e) begin
          total++;
          if (cur_ch !== chk_v[k]) begin
            bad++;
            $display("FAIL wrap_auto e=%0d: ch=%0d want %0d", e, cur_ch, chk_v[k]);
          end
        end
      end
      if (e == 64) step = 1'b1;
      if (e == 80) step = 1'b0;
    end
    auto_en = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    total++;
    if (cur_ch !== 2'd2) begin
      bad++;
      $display("FAIL auto_off: ch=%0d want 2", cur_ch);
    end
  endtask

  // Press pulse lands on the same edge as the rotate tick: one increment only.
  task automatic test_simultaneous();
    int chk_e [6] = '{49, 50, 51, 99, 100, 150};
    logic [1:0] chk_v [6] = '{2'd2, 2'd0, 2'd0, 2'd0, 2'd1, 2'd2};
    auto_en = 1'b1;
    for (int e = 1; e <= 150; e++) begin
      tick();
      for (int k = 0; k < 6; k++) begin
        if (chk_e[k] == e) begin
          total++;
          if (cur_ch !== chk_v[k]) begin
            bad++;
            $display("FAIL simultaneous e=%0d: ch=%0d want %0d", e, cur_ch, chk_v[k]);
          end
        end
      end
      if (e == 44) step = 1'b1;
      if (e == 60) step = 1'b0;
    end
    auto_en = 1'b0;
  endtask

  // cur_ch=2 selects ch2=7654; top digit is either nibble 7 or the tag "2." (24).
  task automatic test_chtag();
    logic [7:0] exp_seg [4];
    logic [3:0] exp_sel;
    logic [3:0] prev;
    logic found;
    int d;
    exp_seg = '{8'h99, 8'h92, 8'h82, 8'hF8};
`ifdef DEBUG_SEG_CHTAG_EN
    exp_seg[3] = 8'h24;
`endif
    for (int i = 0; i < 20; i++) tick();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      prev = o_sel;
      tick();
      if (prev == 4'b0111 && o_sel == 4'b1110) found = 1'b1;
    end
    total++;
    if (!found) begin
      bad++;
      $display("FAIL chtag_frame_start: no frame start within 40 cycles, sel=%b want 1110", o_sel);
    end else begin
      for (int e = 0; e < 16; e++) begin
        if (e != 0) tick();
        d = e / 4;
        exp_sel = 4'b1111;
        exp_sel[d] = 1'b0;
        total++;
        if (o_seg !== exp_seg[d] || o_sel !== exp_sel) begin
          bad++;
          $display("FAIL chtag_digit e=%0d: seg=%h sel=%b want seg=%h sel=%b",
                   e, o_seg, o_sel, exp_seg[d], exp_sel);
        end
      end
    end
  endtask

  // Reset while the button is held: debounced level drops, one fresh pulse follows.
  task automatic test_reset_midpress();
    step = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (cur_ch !== 2'd0) begin
      bad++;
      $display("FAIL midpress_wrap: ch=%0d want 0", cur_ch);
    end
    reset = 1'b0;
    tick();
    tick();
    total++;
    if (cur_ch !== 2'd0 || o_seg !== 8'hFF || o_sel !== 4'b1111) begin
      bad++;
      $display("FAIL midpress_reset: ch=%0d seg=%h sel=%b want 0 ff 1111", cur_ch, o_seg, o_sel);
    end
    reset = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      tick();
      if (i == 5) begin
        total++;
        if (cur_ch !== 2'd0) begin
          bad++;
          $display("FAIL midpress_early: ch=%0d want 0", cur_ch);
        end
      end
    end
    total++;
    if (cur_ch !== 2'd1) begin
      bad++;
      $display("FAIL midpress_pulse: ch=%0d want 1", cur_ch);
    end
    step = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    total++;
    if (cur_ch !== 2'd1) begin
      bad++;
      $display("FAIL midpress_release: ch=%0d want 1", cur_ch);
    end
  endtask

  initial begin
    test_reset();
    test_frame_snapshot();
    test_debounce();
    test_wrap_auto();
    test_simultaneous();
    test_chtag();
    test_reset_midpress();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/debug_seg_mux.md
# debug_seg_mux

Parametrised debug display controller for the single-cycle CPU board top. It takes CH 32-bit debug channels (pc, instruction, register taps, …) and selects one, either by a debounced step button or by timed auto-rotation. It snapshots the selected value once per display frame and drives an active-low multiplexed 7-segment display of DIGITS digits. It replaces the fixed "show pc" display path with a channel-selectable, frame-stable one.

## Interface
Parameters:
- CH, 8, number of 32-bit input channels (2..16)
- DIGITS, 8, number of displayed hex digits (1..8); digit k shows nibble k of the snapshot
- SCAN_DIV, 100000, clk cycles per digit slot
- ROT_DIV, 200000000, clk cycles between auto-rotation advances
- DEB_CYCLES, 1000000, consecutive equal samples needed to accept a new button level

Ports:
- clk  in  1  system clock; the single clock of the block
- reset  in  1  synchronous, active-low reset, sampled on rising clk
- step  in  1  raw, asynchronous push-button; a press advances the channel
- auto_en  in  1  level; 1 = timed channel rotation
- ch_data  in  CH*32  flattened channels; channel i = ch_data[32*i+31 : 32*i]
- o_seg  out  8  segments {dp,g,f,e,d,c,b,a}, active-low
- o_sel  out  DIGITS  digit enables, active-low one-hot
- cur_ch  out  $clog2(CH)  currently selected channel index

## Operation
- Button path: 2-FF synchroniser, then a debounce counter. The debounced level changes only after DEB_CYCLES consecutive samples differ from it. A debounced 0→1 transition produces a 1-cycle step pulse. Release generates no pulse.
- Rotation: when auto_en=1, a counter runs 0..ROT_DIV-1. At ROT_DIV-1 it produces a 1-cycle rotate tick and wraps. When auto_en=0 it is held at 0. A step pulse also clears it.
- Channel: cur_ch increments on a step pulse or a rotate tick and wraps CH-1→0. If both occur in the same cycle, cur_ch increments once.
- Scan: a prescaler counts 0..SCAN_DIV-1. At SCAN_DIV-1 the digit index advances and wraps DIGITS-1→0.
- Frame boundary: the cycle in which the digit index wraps to 0. In that cycle the snapshot register loads the channel selected by cur_ch. The display never mixes channels or values within a frame.
- Decode: selected nibble goes to hex segments with dp off (bit7=1).
  - 0→C0, 1→F9, 2→A4, 3→B0, 4→99, 5→92, 6→82, 7→F8, 8→80, 9→90, A→88, b→83, C→C6, d→A1, E→86, F→8E.
- o_sel drives 0 on the bit for the active digit and 1 elsewhere.

## Timing
- Reset (reset=0 at a clk edge), all within that edge:
  - o_seg=8'hFF, o_sel=all ones, cur_ch=0
  - snapshot=0, prescaler=0, digit index=0
  - rotation counter=0, debounced level=0, synchroniser=0
- First frame after reset shows 0 until the first frame boundary.
- o_seg/o_sel are registered. They reflect a new digit index 1 cycle after the index changes.
- Step latency: raw edge → cur_ch change = 2 (sync) + DEB_CYCLES + 1 cycles.
- Rotate tick → cur_ch change: 1 cycle. The new channel reaches the display at the next frame boundary.
- Snapshot at a frame boundary uses cur_ch as registered before that edge. A same-cycle cur_ch change takes effect next frame.
- Bounces shorter than DEB_CYCLES are ignored completely.
- Reset asserted mid-press: the debounced level returns to 0. A still-held button then produces one pulse after DEB_CYCLES.
- auto_en toggling has effect from the next cycle. No partial tick is carried over.

## Configuration
- DEBUG_SEG_CHTAG_EN defined:
  - The most significant digit (DIGITS-1) shows cur_ch (snapshot copy) as a hex digit with dp lit (bit7=0).
  - The other DIGITS-1 digits show the low nibbles of the snapshot.
- DEBUG_SEG_CHTAG_EN undefined: all DIGITS digits show snapshot nibbles and dp is always off.

## Test plan
Bench parameters: CH=3, DIGITS=4, SCAN_DIV=4, ROT_DIV=50, DEB_CYCLES=3, macro undefined unless stated.
- Reset check: hold reset=0 for 5 cycles → o_seg=FF, o_sel=4'b1111, cur_ch=0. After release and the first frame, digits all show C0 (zero).
- Frame snapshot: ch0=32'h0000_1A2F, auto_en=0. Then change ch0 to 0000_FFFF mid-frame → the current frame still shows F,2,A,1 (8E,A4,88,F9) on o_sel 1110,1101,1011,0111. The next frame shows FFFF.
- Debounce: step toggles every 2 cycles for 20 cycles, then held high 10 cycles → exactly one increment, cur_ch=1, on cycle 2+3+1 after the stable rise.
- Wrap and auto: auto_en=1 from cur_ch=2 → cur_ch=0 at 50 cycles, then 1 at 100. A step pulse at cycle 70 gives cur_ch=1 immediately and the next tick at 120.
- Simultaneous: force a step pulse on the same cycle as a rotate tick → cur_ch advances by 1, not 2.
- DEBUG_SEG_CHTAG_EN defined, cur_ch=2 → the digit-3 slot shows o_seg=24 (2 with dp lit).
